// File: rtl/oflow_core_fsm_fe.sv
// Feature-extraction sequencer: walks a frame's bbox sets, loads PEs, fires FE,
// collects PE completion and waits for downstream consumption before the next set.
module oflow_core_fsm_fe #(
    parameter int PE_NUM          = 24,
    parameter int SET_LEN         = 7,
    parameter int REMAIN_BBOX_LEN = 5,
    parameter int FRAME_WIDTH     = 16
) (
    input  logic                       clk,
    input  logic                       reset_N,
    input  logic                       start_frame,
    input  logic                       frame_abort,
    input  logic [SET_LEN-1:0]         num_of_sets,
    input  logic [REMAIN_BBOX_LEN-1:0] counter_of_remain_bboxes,
    input  logic [FRAME_WIDTH-1:0]     frame_num,
    output logic                       read_req,
    output logic [SET_LEN-1:0]         read_set_idx,
    input  logic                       read_ack,
    output logic [PE_NUM-1:0]          start_fe_i,
    input  logic [PE_NUM-1:0]          done_fe_i,
    output logic                       done_fe,
    input  logic                       done_registration,
    input  logic                       done_score_calc,
    output logic                       busy,
    output logic                       done_frame
);

    // Handshake: read_req is held from LOAD entry until read_ack is sampled high;
    // read_ack, done_registration and done_score_calc are ignored outside the
    // states that listen for them.
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FE,
        S_HAND,
        S_FIN
    } state_t;

    state_t                     state;
    logic [SET_LEN-1:0]         num_sets;
    logic [SET_LEN-1:0]         counter_set_fe;
    logic [REMAIN_BBOX_LEN-1:0] remain;
    logic [FRAME_WIDTH-1:0]     frame_lat;
    logic [PE_NUM-1:0]          done_acc;
    logic [PE_NUM-1:0]          mask;
    logic [PE_NUM-1:0]          acc_next;
    logic                       ds_done;
    logic                       ds_pulse;
    logic                       last_set;

    assign read_set_idx = counter_set_fe;

    // Only the last set of a frame may be partial; remain==0 means a full set.
    always_comb begin
        last_set = (counter_set_fe == num_sets - SET_LEN'(1));
        mask     = '1;
        if (last_set && (remain != '0)) begin
            for (int i = 0; i < PE_NUM; i++) begin
                mask[i] = (i < 32'(remain));
            end
        end
        acc_next = done_acc | (done_fe_i & mask);
        ds_pulse = (frame_lat == '0) ? done_registration : done_score_calc;
    end

    always_ff @(posedge clk or negedge reset_N) begin
        if (!reset_N) begin
            state          <= S_IDLE;
            num_sets       <= '0;
            counter_set_fe <= '0;
            remain         <= '0;
            frame_lat      <= '0;
            done_acc       <= '0;
            ds_done        <= 1'b0;
            read_req       <= 1'b0;
            start_fe_i     <= '0;
            done_fe        <= 1'b0;
            busy           <= 1'b0;
            done_frame     <= 1'b0;
        end else begin
            start_fe_i <= '0;
            done_fe    <= 1'b0;
            done_frame <= 1'b0;
            if (frame_abort) begin
                state          <= S_IDLE;
                counter_set_fe <= '0;
                done_acc       <= '0;
                ds_done        <= 1'b0;
                read_req       <= 1'b0;
                busy           <= 1'b0;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        if (start_frame) begin
                            num_sets       <= num_of_sets;
                            remain         <= counter_of_remain_bboxes;
                            frame_lat      <= frame_num;
                            counter_set_fe <= '0;
                            done_acc       <= '0;
                            ds_done        <= 1'b0;
                            busy           <= 1'b1;
                            if (num_of_sets == '0) begin
                                state <= S_FIN;
                            end else begin
                                state    <= S_LOAD;
                                read_req <= 1'b1;
                            end
                        end
                    end
                    S_LOAD: begin
                        if (read_ack) begin
                            read_req   <= 1'b0;
                            start_fe_i <= mask;
                            state      <= S_FE;
                        end
                    end
                    S_FE: begin
                        // Accumulate from the start cycle so early done pulses are kept.
                        done_acc <= acc_next;
                        if (acc_next == mask) begin
                            done_fe <= 1'b1;
                            state   <= S_HAND;
                        end
                    end
                    S_HAND: begin
                        // A downstream pulse in the done_fe cycle itself counts.
                        if (ds_done || ds_pulse) begin
                            ds_done <= 1'b0;
                            if (last_set) begin
                                state <= S_FIN;
                            end else begin
                                counter_set_fe <= counter_set_fe + SET_LEN'(1);
                                done_acc       <= '0;
                                read_req       <= 1'b1;
                                state          <= S_LOAD;
                            end
                        end
                    end
                    S_FIN: begin
                        done_frame <= 1'b1;
                        busy       <= 1'b0;
                        state      <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_oflow_core_fsm_fe.sv
// Directed bench for the FE sequencer: set walking, masks, downstream gating,
// staggered PE completion, zero-set frames, abort, ignored restarts, async reset.
module tb_oflow_core_fsm_fe;

    logic        clk;
    logic        reset_N;
    logic        start_frame;
    logic        frame_abort;
    logic [6:0]  num_of_sets;
    logic [4:0]  counter_of_remain_bboxes;
    logic [15:0] frame_num;
    logic        read_req;
    logic [6:0]  read_set_idx;
    logic        read_ack;
    logic [23:0] start_fe_i;
    logic [23:0] done_fe_i;
    logic        done_fe;
    logic        done_registration;
    logic        done_score_calc;
    logic        busy;
    logic        done_frame;

    int checks = 0;
    int errors = 0;

    oflow_core_fsm_fe dut (
        .clk                      (clk),
        .reset_N                  (reset_N),
        .start_frame              (start_frame),
        .frame_abort              (frame_abort),
        .num_of_sets              (num_of_sets),
        .counter_of_remain_bboxes (counter_of_remain_bboxes),
        .frame_num                (frame_num),
        .read_req                 (read_req),
        .read_set_idx             (read_set_idx),
        .read_ack                 (read_ack),
        .start_fe_i               (start_fe_i),
        .done_fe_i                (done_fe_i),
        .done_fe                  (done_fe),
        .done_registration        (done_registration),
        .done_score_calc          (done_score_calc),
        .busy                     (busy),
        .done_frame               (done_frame)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [6:0] ns, input logic [4:0] rem, input logic [15:0] fn);
        num_of_sets              = ns;
        counter_of_remain_bboxes = rem;
        frame_num                = fn;
        start_frame              = 1'b1;
        tick();
        start_frame = 1'b0;
    endtask

    task automatic wait_req(input string name);
        int n;
        n = 0;
        while (read_req !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL %s read_req timeout got %b want 1", name, read_req);
        end
    endtask

    // Serves one set: ack after ack_dly, all mask bits done at once,
    // downstream pulse ds_dly cycles after the done_fe cycle.
    task automatic serve_set(input int ack_dly, input int ds_dly, input bit ds_sel,
                             input bit wrong_first, output logic [23:0] m,
                             output logic [6:0] idx, output logic dfe, output logic early);
        early = 1'b0;
        wait_req("serve_set");
        idx = read_set_idx;
        repeat (ack_dly) tick();
        read_ack = 1'b1;
        tick();
        read_ack = 1'b0;
        m = start_fe_i;
        done_fe_i = m;
        tick();
        done_fe_i = '0;
        dfe = done_fe;
        for (int i = 0; i < ds_dly; i++) begin
            if (wrong_first && i == 0) begin
                if (ds_sel) done_registration = 1'b1;
                else        done_score_calc   = 1'b1;
            end
            tick();
            done_registration = 1'b0;
            done_score_calc   = 1'b0;
            if (i == 0) early = read_req;
        end
        if (ds_sel) done_score_calc   = 1'b1;
        else        done_registration = 1'b1;
        tick();
        done_registration = 1'b0;
        done_score_calc   = 1'b0;
    endtask

    // Scenario tasks
    task automatic test_reset();
        reset_N = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({read_req, read_set_idx, start_fe_i, done_fe, busy, done_frame} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got req=%b idx=%0d sfe=%h dfe=%b busy=%b df=%b want all 0",
                     read_req, read_set_idx, start_fe_i, done_fe, busy, done_frame);
        end
        reset_N = 1'b1;
        tick();
    endtask

    task automatic test_frame0();
        logic [23:0] m[3];
        logic [6:0]  ix[3];
        logic        dfe[3];
        logic        early;
        logic [23:0] exp_m[3];
        exp_m = '{24'hFFFFFF, 24'hFFFFFF, 24'h00001F};
        start(7'd3, 5'd5, 16'd0);
        checks++;
        if (busy !== 1'b1 || read_req !== 1'b1) begin
            errors++;
            $display("FAIL f0_first_load got busy=%b req=%b want 1 1", busy, read_req);
        end
        for (int s = 0; s < 3; s++) serve_set(2, 1, 1'b0, 1'b0, m[s], ix[s], dfe[s], early);
        for (int s = 0; s < 3; s++) begin
            checks++;
            if (m[s] !== exp_m[s] || ix[s] !== 7'(s) || dfe[s] !== 1'b1) begin
                errors++;
                $display("FAIL f0_set%0d got mask=%h idx=%0d dfe=%b want %h %0d 1",
                         s, m[s], ix[s], dfe[s], exp_m[s], s);
            end
        end
        checks++;
        if (done_frame !== 1'b0) begin
            errors++;
            $display("FAIL f0_fin_early got done_frame=%b want 0", done_frame);
        end
        tick();
        checks++;
        if (done_frame !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL f0_done_frame got df=%b busy=%b want 1 0", done_frame, busy);
        end
        tick();
        checks++;
        if (done_frame !== 1'b0) begin
            errors++;
            $display("FAIL f0_done_frame_pulse got %b want 0", done_frame);
        end
    endtask

    task automatic test_frame7();
        logic [23:0] m[3];
        logic [6:0]  ix[3];
        logic        dfe[3];
        logic        early0;
        logic        e;
        start(7'd3, 5'd5, 16'd7);
        serve_set(1, 2, 1'b1, 1'b1, m[0], ix[0], dfe[0], early0);
        serve_set(0, 0, 1'b1, 1'b0, m[1], ix[1], dfe[1], e);
        serve_set(3, 0, 1'b1, 1'b0, m[2], ix[2], dfe[2], e);
        checks++;
        if (early0 !== 1'b0) begin
            errors++;
            $display("FAIL f7_reg_ignored got read_req=%b want 0", early0);
        end
        checks++;
        if (ix[1] !== 7'd1 || ix[2] !== 7'd2 || m[2] !== 24'h00001F || m[1] !== 24'hFFFFFF) begin
            errors++;
            $display("FAIL f7_sets got idx=%0d,%0d mask=%h,%h want 1,2 ffffff,00001f",
                     ix[1], ix[2], m[1], m[2]);
        end
        tick();
        checks++;
        if (done_frame !== 1'b1) begin
            errors++;
            $display("FAIL f7_done_frame got %b want 1", done_frame);
        end
        tick();
    endtask

    task automatic test_stagger();
        logic [23:0] pat;
        int          early_cnt;
        logic        fire;
        logic        d1, d2, d3;
        start(7'd2, 5'd3, 16'd0);
        wait_req("stagger0");
        read_ack = 1'b1;
        tick();
        read_ack = 1'b0;
        checks++;
        if (start_fe_i !== 24'hFFFFFF) begin
            errors++;
            $display("FAIL stag_mask0 got %h want ffffff", start_fe_i);
        end
        early_cnt = 0;
        fire = 1'b0;
        for (int j = 0; j < 10; j++) begin
            for (int i = 0; i < 24; i++) pat[i] = ((i % 10) == j);
            done_fe_i = pat;
            tick();
            if (j < 9 && done_fe !== 1'b0) early_cnt++;
            if (j == 9) fire = done_fe;
        end
        done_fe_i = '0;
        checks++;
        if (early_cnt != 0 || fire !== 1'b1) begin
            errors++;
            $display("FAIL stag_done_fe got early=%0d fire=%b want 0 1", early_cnt, fire);
        end
        done_registration = 1'b1;
        tick();
        done_registration = 1'b0;
        checks++;
        if (read_req !== 1'b1 || read_set_idx !== 7'd1) begin
            errors++;
            $display("FAIL stag_next_set got req=%b idx=%0d want 1 1", read_req, read_set_idx);
        end
        read_ack = 1'b1;
        tick();
        read_ack = 1'b0;
        checks++;
        if (start_fe_i !== 24'h000007) begin
            errors++;
            $display("FAIL stag_mask1 got %h want 000007", start_fe_i);
        end
        done_fe_i = 24'hFFFFF8;
        tick();
        d1 = done_fe;
        done_fe_i = 24'h000003;
        tick();
        d2 = done_fe;
        done_fe_i = 24'h000004;
        tick();
        d3 = done_fe;
        done_fe_i = '0;
        checks++;
        if ({d1, d2, d3} !== 3'b001) begin
            errors++;
            $display("FAIL stag_outside_mask got %b%b%b want 001", d1, d2, d3);
        end
        done_registration = 1'b1;
        tick();
        done_registration = 1'b0;
        tick();
        checks++;
        if (done_frame !== 1'b1) begin
            errors++;
            $display("FAIL stag_done_frame got %b want 1", done_frame);
        end
        tick();
    endtask

    task automatic test_zero_sets();
        start(7'd0, 5'd0, 16'd0);
        checks++;
        if (read_req !== 1'b0 || start_fe_i !== '0 || busy !== 1'b1 || done_frame !== 1'b0) begin
            errors++;
            $display("FAIL zero_fin got req=%b sfe=%h busy=%b df=%b want 0 0 1 0",
                     read_req, start_fe_i, busy, done_frame);
        end
        tick();
        checks++;
        if (done_frame !== 1'b1 || read_req !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_done_frame got df=%b req=%b busy=%b want 1 0 0",
                     done_frame, read_req, busy);
        end
        tick();
    endtask

    task automatic test_abort();
        logic [23:0] m0, m1;
        logic [6:0]  i0, i1;
        logic        d0, d1, e;
        int          df_cnt;
        start(7'd4, 5'd0, 16'd0);
        serve_set(0, 0, 1'b0, 1'b0, m0, i0, d0, e);
        wait_req("abort_set1");
        read_ack = 1'b1;
        tick();
        read_ack = 1'b0;
        checks++;
        if (start_fe_i !== 24'hFFFFFF || read_set_idx !== 7'd1) begin
            errors++;
            $display("FAIL abort_fe_entry got sfe=%h idx=%0d want ffffff 1", start_fe_i, read_set_idx);
        end
        tick();
        frame_abort = 1'b1;
        tick();
        frame_abort = 1'b0;
        checks++;
        if ({read_req, read_set_idx, start_fe_i, done_fe, busy, done_frame} !== '0) begin
            errors++;
            $display("FAIL abort_idle got req=%b idx=%0d sfe=%h dfe=%b busy=%b df=%b want all 0",
                     read_req, read_set_idx, start_fe_i, done_fe, busy, done_frame);
        end
        df_cnt = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (done_frame !== 1'b0 || busy !== 1'b0) df_cnt++;
        end
        checks++;
        if (df_cnt != 0) begin
            errors++;
            $display("FAIL abort_quiet got %0d active cycles want 0", df_cnt);
        end
        start(7'd2, 5'd0, 16'd0);
        serve_set(1, 0, 1'b0, 1'b0, m0, i0, d0, e);
        serve_set(1, 1, 1'b0, 1'b0, m1, i1, d1, e);
        checks++;
        if (i0 !== 7'd0 || i1 !== 7'd1 || m0 !== 24'hFFFFFF || m1 !== 24'hFFFFFF) begin
            errors++;
            $display("FAIL abort_restart got idx=%0d,%0d mask=%h,%h want 0,1 ffffff,ffffff",
                     i0, i1, m0, m1);
        end
        tick();
        checks++;
        if (done_frame !== 1'b1) begin
            errors++;
            $display("FAIL abort_restart_df got %b want 1", done_frame);
        end
        tick();
    endtask

    task automatic test_start_ignored();
        logic [23:0] m0, m1;
        logic [6:0]  i0, i1;
        logic        d0, d1, e;
        start(7'd2, 5'd4, 16'd0);
        serve_set(0, 0, 1'b0, 1'b0, m0, i0, d0, e);
        start(7'd5, 5'd0, 16'd3);
        serve_set(0, 0, 1'b0, 1'b0, m1, i1, d1, e);
        checks++;
        if (m1 !== 24'h00000F || i1 !== 7'd1) begin
            errors++;
            $display("FAIL restart_ignored got mask=%h idx=%0d want 00000f 1", m1, i1);
        end
        tick();
        checks++;
        if (done_frame !== 1'b1) begin
            errors++;
            $display("FAIL restart_ignored_df got %b want 1", done_frame);
        end
        tick();
    endtask

    task automatic test_reset_in_load();
        start(7'd2, 5'd0, 16'd0);
        checks++;
        if (read_req !== 1'b1) begin
            errors++;
            $display("FAIL rst_load_req got %b want 1", read_req);
        end
        #2;
        reset_N = 1'b0;
        #1;
        checks++;
        if (read_req !== 1'b0 || busy !== 1'b0 || read_set_idx !== 7'd0) begin
            errors++;
            $display("FAIL rst_async got req=%b busy=%b idx=%0d want 0 0 0", read_req, busy, read_set_idx);
        end
        tick();
        reset_N = 1'b1;
        tick();
    endtask

    initial begin
        start_frame              = 1'b0;
        frame_abort              = 1'b0;
        num_of_sets              = '0;
        counter_of_remain_bboxes = '0;
        frame_num                = '0;
        read_ack                 = 1'b0;
        done_fe_i                = '0;
        done_registration        = 1'b0;
        done_score_calc          = 1'b0;
        test_reset();
        test_frame0();
        test_frame7();
        test_stagger();
        test_zero_sets();
        test_abort();
        test_start_ignored();
        test_reset_in_load();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
